pwl_act_unit: RTL and testbench
===============================

// Module: pwl_act_unit
// PURPOSE
// - Pipelined, parametrised piecewise-linear activation unit in signed fixed point. Supports tanh and sigmoid, selected per transaction.
// - Sits between the accelerator datapath and the result buffer; valid/ready streaming on both sides.
// - One result per cycle throughput, full backpressure.
// - Slopes are shift-add only; no multipliers.
// PARAMETERS
// - DATA_W  32  total width of signed input/output word (two's complement)
// - FRAC_W  14  fractional bits; ONE = 1<<FRAC_W; legal range 4 <= FRAC_W <= DATA_W-4
// PORTS
// - clk        in   1       clock, rising edge
// - rstn       in   1       asynchronous reset, active-low
// - in_valid   in   1       input word valid
// - in_ready   out  1       unit can accept input this cycle
// - in_data    in   DATA_W  signed Q(DATA_W-FRAC_W).FRAC_W operand x
// - in_mode    in   1       0 = tanh(x), 1 = sigmoid(x); captured with in_data
// - out_valid  out  1       result valid
// - out_ready  in   1       downstream accepts result
// - out_data   out  DATA_W  signed result, same Q format
// - busy       out  1       any pipeline stage holds valid data
// BEHAVIOUR
// - Reset: out_valid=0, out_data=0, busy=0, all stage valids=0. in_ready=1 once out of reset.
// - Pipeline: 3 register stages S1->S2->S3; S3 drives out_*.
//   - Latency: 3 cycles from accepted input to out_valid, with no stall.
//   - Stage k loads when !valid_k || ready_k; ready_3 = out_ready.
//   - in_ready = !valid_1 || ready_1 (combinational).
//   - Handshakes fire on valid&&ready; no bubbles while out_ready=1.
// - S1:
//   - sigmoid mode: u = x>>>1; tanh mode: u = x.
//   - s = sign(u); a = |u|, saturated to 2^(DATA_W-1)-1 (|most-negative| saturates).
//   - Classify a into segment; register a, s, seg, mode.
// - S2 segments (c = ONE):
//   - seg0  a < c>>2:                     y = a
//   - seg1  c>>2 <= a < c-(c>>3):         y = a - (a>>2) + (c>>4)
//   - seg2  c-(c>>3) <= a < 2c-(c>>3):    y = (a>>2) + (c>>1)
//   - seg3  2c-(c>>3) <= a < 3c:          y = (a>>5) + c - (c>>4) - (c>>5)
//   - seg4  a >= 3c:                      y = c
//   - Then clamp y to at most c.
// - S3: t = s ? -y : y.
//   - tanh: out = t.
//   - sigmoid: out = (c>>1) + (t>>>1).
//   - Arithmetic shifts only. Internal width DATA_W+1; no overflow possible by construction.
// - Boundaries: breakpoints belong to the upper segment. Output is odd-symmetric in tanh mode; |out| <= ONE.
// - Stall: a held stage keeps data and mode stable; out_data stays stable while out_valid && !out_ready.
// - Simultaneous accept/emit in the same cycle is a legal full-rate transfer.
// - Reset mid-operation drops all in-flight data; no output is emitted for it.
// - in_data and in_mode are sampled only on an in_valid&&in_ready handshake.
// CONFIGURATION
// - PWL_ROUND_EN defined:
//   - Every right shift of a data-dependent term (a>>2, a>>5, t>>>1) rounds half-up.
//   - Rounding adds bit [sh-1] before truncation.
//   - Constant terms are unchanged.
// - PWL_ROUND_EN undefined: all shifts truncate toward -inf (arithmetic) / zero (magnitude).
// TESTING (FRAC_W=14, ONE=0x4000, DATA_W=32)
// - tanh x=0x00000800 (0.125), out_ready=1 -> out_data=0x00000800 exactly 3 cycles after accept.
// - tanh x=0xFFFFC000 (-1.0) -> 0xFFFFD000 (-0.75); tanh x=0x0000C000 (3.0) -> 0x00004000.
// - tanh x=0x7FFFFFFF -> 0x00004000; x=0x80000000 -> 0xFFFFC000; sigmoid x=0 -> 0x00002000.
// - tanh x=0x00002002 -> 0x00001C02 without PWL_ROUND_EN, 0x00001C01 with it.
// - 5 back-to-back inputs, out_ready low for 4 cycles:
//   - in_ready drops once S1..S3 are full.
//   - No loss or duplication; outputs arrive in order, paired with the correct mode.
// - rstn low while 3 transactions are in flight -> out_valid=0 and busy=0 immediately; no stale output after release.

Source files
------------

// File: rtl/pwl_act_unit.sv
// Three-stage piecewise-linear tanh/sigmoid unit, signed fixed point, valid/ready on both sides.
// Optional build macro PWL_ROUND_EN: data-dependent right shifts round half-up instead of truncating.
module pwl_act_unit #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 14
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);
  localparam int STAGES = 3;
  localparam logic [DATA_W-1:0] ONE  = {{(DATA_W-1){1'b0}}, 1'b1} << FRAC_W;
  localparam logic [DATA_W-1:0] B1   = ONE >> 2;
  localparam logic [DATA_W-1:0] B2   = ONE - (ONE >> 3);
  localparam logic [DATA_W-1:0] B3   = (ONE << 1) - (ONE >> 3);
  localparam logic [DATA_W-1:0] B4   = (ONE << 1) + ONE;
  localparam logic [DATA_W-1:0] K1   = ONE >> 4;
  localparam logic [DATA_W-1:0] K2   = ONE >> 1;
  localparam logic [DATA_W-1:0] K3   = ONE - (ONE >> 4) - (ONE >> 5);
  localparam logic [DATA_W-1:0] AMAX = {1'b0, {(DATA_W-1){1'b1}}};

  logic [STAGES:1] vld_pipe;
  logic rdy1, rdy2, rdy3;

  // Each stage advances when it is empty or its successor will take its contents.
  assign rdy3      = out_ready;
  assign rdy2      = !vld_pipe[3] || rdy3;
  assign rdy1      = !vld_pipe[2] || rdy2;
  assign in_ready  = !vld_pipe[1] || rdy1;
  assign out_valid = vld_pipe[3];
  assign busy      = |vld_pipe;

  // S1: pre-scale for sigmoid, split into sign/magnitude, classify.
  logic signed [DATA_W-1:0] u;
  logic [DATA_W-1:0] a_c;
  logic [2:0]        seg_c;

  always_comb begin
    u = in_mode ? ($signed(in_data) >>> 1) : $signed(in_data);
    if (u[DATA_W-1] && (u[DATA_W-2:0] == '0)) a_c = AMAX;
    else if (u[DATA_W-1])                     a_c = -u;
    else                                      a_c = u;
    if      (a_c < B1) seg_c = 3'd0;
    else if (a_c < B2) seg_c = 3'd1;
    else if (a_c < B3) seg_c = 3'd2;
    else if (a_c < B4) seg_c = 3'd3;
    else               seg_c = 3'd4;
  end

  logic [DATA_W-1:0] a_q1;
  logic [2:0]        seg_q1;
  logic              s_q1, mode_q1;

  // S2: segment evaluation with shift-add slopes.
  logic [DATA_W-1:0] a_sh2, a_sh5, y_c;
`ifdef PWL_ROUND_EN
  assign a_sh2 = (a_q1 >> 2) + {{(DATA_W-1){1'b0}}, a_q1[1]};
  assign a_sh5 = (a_q1 >> 5) + {{(DATA_W-1){1'b0}}, a_q1[4]};
`else
  assign a_sh2 = a_q1 >> 2;
  assign a_sh5 = a_q1 >> 5;
`endif

  always_comb begin
    case (seg_q1)
      3'd0:    y_c = a_q1;
      3'd1:    y_c = a_q1 - a_sh2 + K1;
      3'd2:    y_c = a_sh2 + K2;
      3'd3:    y_c = a_sh5 + K3;
      default: y_c = ONE;
    endcase
    if (y_c > ONE) y_c = ONE;
  end

  logic [DATA_W-1:0] y_q2;
  logic              s_q2, mode_q2;

  // S3: restore sign, then remap to sigmoid range if requested.
  logic signed [DATA_W:0]   t, t_sh1;
  logic        [DATA_W-1:0] o_c;

  always_comb begin
    t = $signed({1'b0, y_q2});
    if (s_q2) t = -t;
    t_sh1 = t >>> 1;
`ifdef PWL_ROUND_EN
    t_sh1 = t_sh1 + $signed({{DATA_W{1'b0}}, t[0]});
`endif
    o_c = mode_q2 ? DATA_W'($signed({1'b0, K2}) + t_sh1) : DATA_W'(t);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe <= '0;
      a_q1     <= '0;
      seg_q1   <= '0;
      s_q1     <= 1'b0;
      mode_q1  <= 1'b0;
      y_q2     <= '0;
      s_q2     <= 1'b0;
      mode_q2  <= 1'b0;
      out_data <= '0;
    end else begin
      if (in_ready) vld_pipe[1] <= in_valid;
      if (rdy1)     vld_pipe[2] <= vld_pipe[1];
      if (rdy2)     vld_pipe[3] <= vld_pipe[2];
      if (in_ready && in_valid) begin
        a_q1    <= a_c;
        seg_q1  <= seg_c;
        s_q1    <= u[DATA_W-1];
        mode_q1 <= in_mode;
      end
      if (rdy1 && vld_pipe[1]) begin
        y_q2    <= y_c;
        s_q2    <= s_q1;
        mode_q2 <= mode_q1;
      end
      if (rdy2 && vld_pipe[2]) out_data <= o_c;
    end
  end
endmodule

// File: tb/tb_pwl_act_unit.sv
// Directed bench for pwl_act_unit (DATA_W=32, FRAC_W=14); expectations worked by hand.
module tb_pwl_act_unit;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        busy;
  int checks = 0;
  int errors = 0;

  pwl_act_unit #(.DATA_W(32), .FRAC_W(14)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Push one word into an empty pipe with out_ready high and return the result.
  task automatic send(input logic [31:0] x, input logic m, output logic [31:0] r, output bit tmo);
    in_valid = 1'b1; in_data = x; in_mode = m; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 10 && !out_valid; k++) begin
      @(posedge clk); #1;
    end
    tmo = !out_valid;
    r = out_data;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h exp 00000000", out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    @(posedge clk); #1; rstn = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_latency();
    in_valid = 1'b1; in_data = 32'h0000_0800; in_mode = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_c1 got %b exp 0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_c2 got %b exp 0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_c3 got %b exp 1", out_valid); end
    checks++; if (out_data !== 32'h0000_0800) begin errors++; $display("FAIL lat_data got %h exp 00000800", out_data); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lat_drain_busy got %b exp 0", busy); end
  endtask

  task automatic test_tanh();
    logic [31:0] xs [9] = '{32'hFFFF_C000, 32'h0000_C000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_37FC,
                            32'hFFFF_C804, 32'h0000_7800, 32'h0000_77FC, 32'h0000_BFE0};
    logic [31:0] ex [9] = '{32'hFFFF_D000, 32'h0000_4000, 32'h0000_4000, 32'hFFFF_C000, 32'h0000_2DFD,
                            32'hFFFF_D203, 32'h0000_3DC0, 32'h0000_3DFF, 32'h0000_3FFF};
    logic [31:0] r; bit tmo;
    for (int i = 0; i < 9; i++) begin
      send(xs[i], 1'b0, r, tmo);
      checks++;
      if (tmo || r !== ex[i]) begin
        errors++; $display("FAIL tanh[%0d] x=%h got %h exp %h tmo=%0d", i, xs[i], r, ex[i], tmo);
      end
    end
  endtask

  task automatic test_sigmoid();
    logic [31:0] xs [5] = '{32'h0000_0000, 32'h0000_8000, 32'hFFFF_8000, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [31:0] ex [5] = '{32'h0000_2000, 32'h0000_3800, 32'h0000_0800, 32'h0000_4000, 32'h0000_0000};
    logic [31:0] r; bit tmo;
    for (int i = 0; i < 5; i++) begin
      send(xs[i], 1'b1, r, tmo);
      checks++;
      if (tmo || r !== ex[i]) begin
        errors++; $display("FAIL sigm[%0d] x=%h got %h exp %h tmo=%0d", i, xs[i], r, ex[i], tmo);
      end
    end
  endtask

  task automatic test_rounding();
    logic [31:0] r; bit tmo;
    logic [31:0] e0, e1, e2;
`ifdef PWL_ROUND_EN
    e0 = 32'h0000_1C01; e1 = 32'h0000_2401; e2 = 32'h0000_1C00;
`else
    e0 = 32'h0000_1C02; e1 = 32'h0000_2400; e2 = 32'h0000_1BFF;
`endif
    send(32'h0000_2002, 1'b0, r, tmo);
    checks++; if (tmo || r !== e0) begin errors++; $display("FAIL rnd_tanh got %h exp %h", r, e0); end
    send(32'h0000_1002, 1'b1, r, tmo);
    checks++; if (tmo || r !== e1) begin errors++; $display("FAIL rnd_sigm_pos got %h exp %h", r, e1); end
    send(32'hFFFF_EFFE, 1'b1, r, tmo);
    checks++; if (tmo || r !== e2) begin errors++; $display("FAIL rnd_sigm_neg got %h exp %h", r, e2); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] xs [5] = '{32'h0000_0800, 32'h0000_8000, 32'hFFFF_C000, 32'hFFFF_8000, 32'h0000_C000};
    logic        ms [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ex [5] = '{32'h0000_0800, 32'h0000_3800, 32'hFFFF_D000, 32'h0000_0800, 32'h0000_4000};
    int nin = 0, nout = 0, cyc = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = xs[0]; in_mode = ms[0];
    while (nout < 5 && cyc < 40) begin
      @(negedge clk);
      if (cyc == 3) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_in_ready got %b exp 0", in_ready); end
        checks++; if (out_data !== ex[0]) begin errors++; $display("FAIL b2b_stall_data got %h exp %h", out_data, ex[0]); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== ex[nout]) begin
          errors++; $display("FAIL b2b_out[%0d] got %h exp %h", nout, out_data, ex[nout]);
        end
        nout++;
      end
      if (in_valid && in_ready) nin++;
      @(posedge clk); #1;
      cyc++;
      in_valid = (nin < 5);
      if (nin < 5) begin in_data = xs[nin]; in_mode = ms[nin]; end
      out_ready = (cyc >= 4);
    end
    checks++; if (nout != 5) begin errors++; $display("FAIL b2b_count got %0d exp 5", nout); end
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain got busy=%b out_valid=%b exp 0/0", busy, out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    bit seen = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'h0000_1000 + 32'(i); in_mode = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre_busy got %b exp 1", busy); end
    rstn = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    @(posedge clk); #1; rstn = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL rstmid_stale got out_valid=1 exp none"); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_tanh();
    test_sigmoid();
    test_rounding();
    test_back_to_back();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
